// File: rtl/vTPU_pkg.sv
// Shared types and constants for the accumulator address sequencer.
package vTPU_pkg;

  // Sequencing mode captured on load.
  typedef enum logic {
    SEQ_WRAP    = 1'b0,
    SEQ_ONESHOT = 1'b1
  } acc_seq_mode_t;

  // Channel-0 sequencer state, also exported for debug.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } acc_seq_state_t;

  // Pass length used when a load supplies len_in = 0.
  localparam int MATRIX_WIDTH_DEFAULT = 14;

endpackage

// File: rtl/skew_delay_line.sv
// Enable-qualified delay line: o_q is i_d delayed by DEPTH enabled cycles.
// The whole line freezes while i_en is low.
module skew_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_pipe [DEPTH];

  // Shift one stage per enabled cycle; synchronous clear on rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
    end else if (i_en) begin
      r_pipe[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_q = r_pipe[DEPTH-1];

endmodule

// File: rtl/acc_addr_sequencer.sv
// Accumulator address sequencer: channel 0 walks start, start+stride, ...
// for len addresses (wrapping or one-shot); channels 1..NUM_CH-1 replay the
// channel-0 stream delayed by k enabled cycles for systolic skew.
//
// Handshake: there is no back-pressure. load is a single-cycle command that
// is always accepted (unless rst); enable is a global advance that moves the
// channel-0 sequence and every skew stage together. count_vld[k] qualifies
// count_val slice k and wrap[k] in the same cycle.
module acc_addr_sequencer
  import vTPU_pkg::*;
#(
  parameter int COUNTER_WIDTH = 32,
  parameter int MATRIX_WIDTH  = MATRIX_WIDTH_DEFAULT,
  parameter int NUM_CH        = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            enable,
  input  logic                            load,
  input  logic [COUNTER_WIDTH-1:0]        start_val,
  input  logic [COUNTER_WIDTH-1:0]        len_in,
  input  logic [COUNTER_WIDTH-1:0]        stride_in,
  input  logic                            mode_in,
  output logic [NUM_CH*COUNTER_WIDTH-1:0] count_val,
  output logic [NUM_CH-1:0]               count_vld,
  output logic [NUM_CH-1:0]               wrap,
  output logic                            busy,
  output logic                            done,
  output acc_seq_state_t                  dbg_state
);

  localparam int CW = COUNTER_WIDTH;
  // Per-channel bundle: {oneshot, wrap, vld, count}
  localparam int BW = CW + 3;

  acc_seq_state_t r_state;
  acc_seq_mode_t  r_mode;
  logic [CW-1:0]  r_start;
  logic [CW-1:0]  r_len;
  logic [CW-1:0]  r_stride;
  logic [CW-1:0]  r_count;
  logic [CW-1:0]  r_idx;
  logic           r_vld;
  logic           r_wrap;
  logic           r_done;

  logic [CW-1:0]  w_len_eff;
  logic [CW-1:0]  w_idx_inc;
  logic           w_last_idx;
  logic           w_c0_nvld;
  logic           w_last_nvld;
  logic [BW-1:0]  w_last;
  logic [BW-1:0]  w_ch [NUM_CH];

  assign w_len_eff  = (len_in == '0) ? CW'(MATRIX_WIDTH) : len_in;
  assign w_idx_inc  = r_idx + CW'(1);
  assign w_last_idx = (r_idx == (r_len - CW'(1)));

  // Channel-0 valid as it will be after this edge (used for done with NUM_CH=1).
  assign w_c0_nvld = load |
                     (r_vld & ~(enable & (r_state == ST_RUN) & w_last_idx &
                                (r_mode == SEQ_ONESHOT)));

  // Channel-0 FSM: load restarts from any state, enable advances in RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_mode   <= SEQ_WRAP;
      r_start  <= '0;
      r_len    <= '0;
      r_stride <= '0;
      r_count  <= '0;
      r_idx    <= '0;
      r_vld    <= 1'b0;
      r_wrap   <= 1'b0;
    end else if (load) begin
      r_state  <= ST_RUN;
      r_mode   <= acc_seq_mode_t'(mode_in);
      r_start  <= start_val;
      r_len    <= w_len_eff;
      r_stride <= stride_in;
      r_count  <= start_val;
      r_idx    <= '0;
      r_vld    <= 1'b1;
      r_wrap   <= (w_len_eff == CW'(1));
    end else if (enable && (r_state == ST_RUN)) begin
      if (!w_last_idx) begin
        r_count <= r_count + r_stride;
        r_idx   <= w_idx_inc;
        r_wrap  <= (w_idx_inc == (r_len - CW'(1)));
      end else if (r_mode == SEQ_WRAP) begin
        r_count <= r_start;
        r_idx   <= '0;
        r_wrap  <= (r_len == CW'(1));
      end else begin
        // One-shot pass finished: count holds its last address.
        r_state <= ST_IDLE;
        r_vld   <= 1'b0;
        r_wrap  <= 1'b0;
      end
    end
  end

  assign w_ch[0] = {(r_mode == SEQ_ONESHOT), r_wrap, r_vld, r_count};

  for (genvar k = 1; k < NUM_CH; k++) begin : g_skew
    skew_delay_line #(
      .WIDTH (BW),
      .DEPTH (k)
    ) u_skew (
      .clk  (clk),
      .rst  (rst),
      .i_en (enable),
      .i_d  (w_ch[0]),
      .o_q  (w_ch[k])
    );
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_out
    assign count_val[k*CW +: CW] = w_ch[k][CW-1:0];
    assign count_vld[k]          = w_ch[k][CW];
    assign wrap[k]               = w_ch[k][CW+1];
  end

  // Next-cycle valid of the last channel: it takes its predecessor on enable.
  if (NUM_CH == 1) begin : g_nvld_single
    assign w_last_nvld = w_c0_nvld;
  end else begin : g_nvld_multi
    assign w_last_nvld = enable ? w_ch[NUM_CH-2][CW] : w_ch[NUM_CH-1][CW];
  end

  assign w_last = w_ch[NUM_CH-1];

  // done: last channel was showing a one-shot wrap and its valid now drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_last[CW] & w_last[CW+1] & w_last[CW+2] & ~w_last_nvld;
    end
  end

  assign busy      = (r_state == ST_RUN);
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_acc_addr_sequencer.sv
// Bench for acc_addr_sequencer: directed vector table, hand-written corner
// sequences and randomized traffic, all checked against an arithmetic model.
module tb_acc_addr_sequencer;
  import vTPU_pkg::*;

  localparam int CW     = 32;
  localparam int NUM_CH = 4;
  localparam int MW     = 14;
  localparam int BW     = CW + 3;
  localparam int OW     = NUM_CH * CW;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, enable, load, mode_in;
  logic [CW-1:0]     start_val, len_in, stride_in;
  logic [OW-1:0]     count_val;
  logic [NUM_CH-1:0] count_vld, wrap;
  logic              busy, done;
  acc_seq_state_t    dbg_state;

  acc_addr_sequencer #(
    .COUNTER_WIDTH (CW),
    .MATRIX_WIDTH  (MW),
    .NUM_CH        (NUM_CH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .load      (load),
    .start_val (start_val),
    .len_in    (len_in),
    .stride_in (stride_in),
    .mode_in   (mode_in),
    .count_val (count_val),
    .count_vld (count_vld),
    .wrap      (wrap),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // ---------------- reference model ----------------
  // Channel 0 address = start + n*stride where n is the position in the pass.
  logic          m_busy;
  logic          m_mode;
  logic [CW-1:0] m_start, m_len, m_stride, m_pos, m_last;
  logic          m_done;
  // Scoreboard: channel-0 bundles {oneshot, wrap, vld, count} seen at past
  // enabled edges, newest first; channel k shows exp_q[k-1].
  logic [BW-1:0] exp_q[$];

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [BW-1:0] model_ch0();
    logic [CW-1:0] a;
    logic          w;
    if (m_busy) begin
      a = m_start + m_pos * m_stride;
      w = (m_pos == m_len - 1);
      return {m_mode, w, 1'b1, a};
    end
    return {m_mode, 1'b0, 1'b0, m_last};
  endfunction

  function automatic logic [BW-1:0] model_ch(int k);
    if (k == 0) return model_ch0();
    return exp_q[k-1];
  endfunction

  task automatic model_edge(input logic r, en, ld, input logic [CW-1:0] sv, li, si,
                            input logic mo);
    logic [BW-1:0] old_last, new_last, old_c0;
    if (r) begin
      m_busy = 1'b0; m_mode = 1'b0;
      m_start = '0; m_len = '0; m_stride = '0; m_pos = '0; m_last = '0;
      m_done = 1'b0;
      exp_q.delete();
      for (int i = 0; i < NUM_CH - 1; i++) exp_q.push_back('0);
      return;
    end
    old_last = model_ch(NUM_CH - 1);
    old_c0   = model_ch0();
    if (en) begin
      exp_q.push_front(old_c0);
      void'(exp_q.pop_back());
    end
    if (ld) begin
      m_start  = sv;
      m_len    = (li == 0) ? CW'(MW) : li;
      m_stride = si;
      m_mode   = mo;
      m_busy   = 1'b1;
      m_pos    = '0;
    end else if (en && m_busy) begin
      if (m_pos == m_len - 1) begin
        if (m_mode == 1'b0) m_pos = '0;
        else begin
          m_busy = 1'b0;
          m_last = m_start + (m_len - 1) * m_stride;
        end
      end else begin
        m_pos = m_pos + 1;
      end
    end
    new_last = model_ch(NUM_CH - 1);
    m_done = old_last[CW] & old_last[CW+1] & old_last[CW+2] & ~new_last[CW];
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_all();
    logic [OW-1:0]     e_cnt;
    logic [NUM_CH-1:0] e_vld, e_wrp;
    logic [BW-1:0]     b;
    for (int k = 0; k < NUM_CH; k++) begin
      b = model_ch(k);
      e_cnt[k*CW +: CW] = b[CW-1:0];
      e_vld[k]          = b[CW];
      e_wrp[k]          = b[CW+1];
    end
    check("count_val", count_val, e_cnt);
    check("count_vld", OW'(count_vld), OW'(e_vld));
    check("wrap", OW'(wrap), OW'(e_wrp));
    check("busy", OW'(busy), OW'(m_busy));
    check("done", OW'(done), OW'(m_done));
    check("state", OW'(dbg_state), OW'(m_busy));
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic r, en, ld, input logic [CW-1:0] sv, li, si,
                      input logic mo);
    rst = r; enable = en; load = ld;
    start_val = sv; len_in = li; stride_in = si; mode_in = mo;
    @(posedge clk);
    model_edge(r, en, ld, sv, li, si, mo);
    #1;
    check_all();
  endtask

  task automatic idle_en(input logic en);
    step(1'b0, en, 1'b0, '0, '0, '0, 1'b0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          r, en, ld;
    logic [CW-1:0] sv, li, si;
    logic          mo;
    logic [CW-1:0] e_cnt;
    logic          e_vld, e_wrap, e_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, en, ld, logic [CW-1:0] sv, li, si, logic mo,
                              logic [CW-1:0] e_cnt, logic e_vld, e_wrap, e_busy);
    vec_t v;
    v.r = r; v.en = en; v.ld = ld; v.sv = sv; v.li = li; v.si = si; v.mo = mo;
    v.e_cnt = e_cnt; v.e_vld = e_vld; v.e_wrap = e_wrap; v.e_busy = e_busy;
    return v;
  endfunction

  initial begin
    // Fields: rst en ld start len stride mode | ch0 count vld wrap busy
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,                    0,            0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 100, 4, 2, 0,                  100,          1, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0,                    102,          1, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0,                    104,          1, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0,                    106,          1, 1, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0,                    100,          1, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0,                    102,          1, 0, 1));
    vecs.push_back(mk(0, 1, 1, 32'hFFFF_FFFE, 3, 3, 1,        32'hFFFF_FFFE, 1, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0,                    32'h0000_0001, 1, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0,                    32'h0000_0004, 1, 1, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0,                    32'h0000_0004, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0,                    32'h0000_0004, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 9, 1, 5, 0,                    9,            1, 1, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0,                    9,            1, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,                    9,            1, 1, 1));
    vecs.push_back(mk(0, 1, 1, 7, 5, 1, 0,                    7,            1, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0,                    8,            1, 0, 1));
    vecs.push_back(mk(1, 1, 1, 50, 4, 1, 0,                   0,            0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0,                    0,            0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].r, vecs[i].en, vecs[i].ld, vecs[i].sv, vecs[i].li, vecs[i].si, vecs[i].mo);
      check($sformatf("vec%0d_cnt0", i), OW'(count_val[CW-1:0]), OW'(vecs[i].e_cnt));
      check($sformatf("vec%0d_vld0", i), OW'(count_vld[0]), OW'(vecs[i].e_vld));
      check($sformatf("vec%0d_wrap0", i), OW'(wrap[0]), OW'(vecs[i].e_wrap));
      check($sformatf("vec%0d_busy", i), OW'(busy), OW'(vecs[i].e_busy));
    end

    // One-shot pass with done on the last channel: load edge is E0, ch0 goes
    // idle at E3, channel 3 drops valid at E6.
    step(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'd0, 32'd3, 32'd1, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      idle_en(1'b1);
      if (i == 3) check("oneshot_busy_low", OW'(busy), OW'(0));
      if (i == 6) check("oneshot_done_pulse", OW'(done), OW'(1));
      if (i == 7) check("oneshot_done_single", OW'(done), OW'(0));
    end

    // Stall for five cycles mid-sequence, then resume.
    step(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'd100, 32'd4, 32'd2, 1'b0);
    idle_en(1'b1);
    idle_en(1'b1);
    for (int i = 0; i < 5; i++) begin
      idle_en(1'b0);
      check("stall_cnt0", OW'(count_val[CW-1:0]), OW'(104));
      check("stall_cnt1", OW'(count_val[2*CW-1:CW]), OW'(102));
    end
    idle_en(1'b1);
    check("resume_cnt0", OW'(count_val[CW-1:0]), OW'(106));
    check("resume_wrap0", OW'(wrap[0]), OW'(1));
    check("resume_cnt1", OW'(count_val[2*CW-1:CW]), OW'(104));

    // len_in = 0 selects the default pass length of 14: addresses 5..18.
    step(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'd5, 32'd0, 32'd1, 1'b0);
    for (int i = 1; i <= 14; i++) begin
      idle_en(1'b1);
      if (i == 12) check("deflen_prewrap", OW'(wrap[0]), OW'(0));
      if (i == 13) begin
        check("deflen_last_cnt", OW'(count_val[CW-1:0]), OW'(18));
        check("deflen_last_wrap", OW'(wrap[0]), OW'(1));
      end
      if (i == 14) check("deflen_restart", OW'(count_val[CW-1:0]), OW'(5));
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      logic r, en, ld, mo;
      logic [CW-1:0] sv, li, si;
      r  = ($urandom_range(0, 99) == 0);
      ld = ($urandom_range(0, 99) < 7);
      en = ($urandom_range(0, 99) < 80);
      sv = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + CW'($urandom_range(0, 15))) : $urandom;
      li = CW'($urandom_range(0, 6));
      si = ($urandom_range(0, 3) == 0) ? $urandom : CW'($urandom_range(0, 4));
      mo = 1'($urandom_range(0, 1));
      step(r, en, ld, sv, li, si, mo);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
